// File: rtl/syscall_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syscall_pkg
// Description : Service codes and walker state encoding for syscall_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package syscall_pkg;

    localparam int SYS_PRINT_INT  = 1;
    localparam int SYS_PRINT_STR  = 4;
    localparam int SYS_EXIT       = 10;
    localparam int SYS_PRINT_CHAR = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/syscall_if.sv
`default_nettype none
// ============================================================================
// Module      : syscall_if
// Description : Pipeline, byte-read port and display-sink signals of syscall_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface syscall_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              sig_syscall;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] a0;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              mem_valid;
    logic              char_valid;
    logic [7:0]        char_data;
    logic              int_valid;
    logic [DATA_W-1:0] int_data;
    logic              exit_req;
    logic              err_overlong;
    logic              err_badcode;

    // Environment side: pipeline plus byte memory plus display sink
    modport master (
        output sig_syscall, v0, a0, mem_rdata, mem_valid,
        input  stall, mem_req, mem_addr, char_valid, char_data,
               int_valid, int_data, exit_req, err_overlong, err_badcode
    );

    modport slave (
        input  sig_syscall, v0, a0, mem_rdata, mem_valid,
        output stall, mem_req, mem_addr, char_valid, char_data,
               int_valid, int_data, exit_req, err_overlong, err_badcode
    );
endinterface
`default_nettype wire

// File: rtl/syscall_str_walker.sv
`default_nettype none
// ============================================================================
// Module      : syscall_str_walker
// Description : Walks a NUL-terminated string one byte per request.
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_str_walker
    import syscall_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MAX_STR_LEN = 256
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] start_addr,
    input  wire logic              mem_valid,
    input  wire logic [7:0]        mem_rdata,
    output logic                   busy,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   got_char,
    output logic                   overlong
);
    localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);
    assign busy        = (r_state != IDLE);
    assign mem_addr    = r_addr;

    always_comb begin
        w_next   = r_state;
        got_char = 1'b0;
        overlong = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = REQ;
            REQ:  w_next = WAIT;
            WAIT: begin
                if (mem_valid) begin
                    if (mem_rdata == 8'd0) begin
                        w_next = IDLE;
                    end else begin
                        got_char = 1'b1;
                        // Truncate once the limit of non-NUL characters is reached
                        if (w_count_inc == CNT_W'(MAX_STR_LEN)) begin
                            overlong = 1'b1;
                            w_next   = IDLE;
                        end else begin
                            w_next = REQ;
                        end
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (start && (r_state == IDLE)) begin
                r_addr  <= start_addr;
                r_count <= '0;
            end else if (got_char) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_count <= w_count_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/syscall_unit.sv
`default_nettype none
// ============================================================================
// Module      : syscall_unit
// Description : SYSCALL service unit: print int/char/string, exit, sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MAX_STR_LEN = 256
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    syscall_if.slave   bus
);
    logic              w_busy;
    logic              w_accept;
    logic              w_is_int;
    logic              w_is_str;
    logic              w_is_exit;
    logic              w_is_char;
    logic              w_is_bad;
    logic              w_got_char;
    logic              w_overlong;
    logic              r_char_valid;
    logic [7:0]        r_char_data;
    logic              r_int_valid;
    logic [DATA_W-1:0] r_int_data;
    logic              r_exit_req;
    logic              r_err_overlong;
    logic              r_err_badcode;

    assign w_is_int  = (bus.v0 == DATA_W'(SYS_PRINT_INT));
    assign w_is_str  = (bus.v0 == DATA_W'(SYS_PRINT_STR));
    assign w_is_exit = (bus.v0 == DATA_W'(SYS_EXIT));
    assign w_is_char = (bus.v0 == DATA_W'(SYS_PRINT_CHAR));
    assign w_is_bad  = ~(w_is_int | w_is_str | w_is_exit | w_is_char);

    // While walking, a held sig_syscall is the same stalled instruction
    assign w_accept  = ~w_busy & bus.sig_syscall & ~r_exit_req;

    syscall_str_walker #(
        .ADDR_W      (ADDR_W),
        .MAX_STR_LEN (MAX_STR_LEN)
    ) u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_accept & w_is_str),
        .start_addr (ADDR_W'(bus.a0)),
        .mem_valid  (bus.mem_valid),
        .mem_rdata  (bus.mem_rdata),
        .busy       (w_busy),
        .mem_addr   (bus.mem_addr),
        .got_char   (w_got_char),
        .overlong   (w_overlong)
    );

    assign bus.stall        = w_busy | (w_accept & w_is_str);
    assign bus.mem_req      = w_busy;
    assign bus.char_valid   = r_char_valid;
    assign bus.char_data    = r_char_data;
    assign bus.int_valid    = r_int_valid;
    assign bus.int_data     = r_int_data;
    assign bus.exit_req     = r_exit_req;
    assign bus.err_overlong = r_err_overlong;
    assign bus.err_badcode  = r_err_badcode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_char_valid   <= 1'b0;
            r_char_data    <= 8'd0;
            r_int_valid    <= 1'b0;
            r_int_data     <= '0;
            r_exit_req     <= 1'b0;
            r_err_overlong <= 1'b0;
            r_err_badcode  <= 1'b0;
        end else begin
            r_int_valid  <= w_accept & w_is_int;
            r_char_valid <= w_got_char | (w_accept & w_is_char);
            if (w_accept && w_is_int) r_int_data <= bus.a0;
            // Walker bytes only arrive outside IDLE, so they never collide with print-char
            if (w_got_char) begin
                r_char_data <= bus.mem_rdata;
            end else if (w_accept && w_is_char) begin
                r_char_data <= bus.a0[7:0];
            end
            if (w_accept && w_is_exit) r_exit_req     <= 1'b1;
            if (w_overlong)            r_err_overlong <= 1'b1;
            if (w_accept && w_is_bad)  r_err_badcode  <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_syscall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_syscall_unit
// Description : Directed self-checking bench for syscall_unit (MAX_STR_LEN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syscall_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    syscall_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    syscall_unit #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .MAX_STR_LEN (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory; unmapped addresses read as '*'
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] served_q [$];
    logic [7:0]  chars_q  [$];
    int          unstable;
    int          dly_tab [4] = '{0, 3, 1, 2};
    int          dly_idx;
    int          dly_force;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h2A;
    endfunction

    // Memory responder: a request starts when mem_req is seen idle, answers after the delay
    initial begin
        bit          busy;
        int          cnt;
        logic [31:0] req_addr;
        busy = 0; cnt = 0; req_addr = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 8'd0;
        forever begin
            @(posedge clk); #1;
            bus.mem_valid = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else if (busy) begin
                if (bus.mem_addr !== req_addr || bus.mem_req !== 1'b1) unstable++;
                if (cnt == 0) begin
                    bus.mem_valid = 1'b1;
                    bus.mem_rdata = mem_byte(req_addr);
                    served_q.push_back(req_addr);
                    busy = 0;
                end else begin
                    cnt--;
                end
            end else if (bus.mem_req === 1'b1) begin
                busy     = 1;
                req_addr = bus.mem_addr;
                cnt      = (dly_force >= 0) ? dly_force : dly_tab[dly_idx % 4];
                dly_idx++;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.char_valid === 1'b1) chars_q.push_back(bus.char_data);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic s, input logic [31:0] v, input logic [31:0] a);
        bus.sig_syscall = s; bus.v0 = v; bus.a0 = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        tick(); tick();
        checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else passed++;
        checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); else passed++;
        checks++; if (bus.mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else passed++;
        checks++; if ({bus.char_valid, bus.int_valid, bus.char_data} !== 10'd0)
            $display("FAIL reset_strobes: got %b/%b/%h want 0", bus.char_valid, bus.int_valid, bus.char_data); else passed++;
        checks++; if (bus.int_data !== 32'd0) $display("FAIL reset_int_data: got %h want 0", bus.int_data); else passed++;
        checks++; if ({bus.exit_req, bus.err_overlong, bus.err_badcode} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {bus.exit_req, bus.err_overlong, bus.err_badcode}); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_int_char();
        drive(1'b1, 32'd1, 32'hFFFF_FFFB);
        #1;
        checks++; if (bus.stall !== 1'b0) $display("FAIL int_accept_stall: got %b want 0", bus.stall); else passed++;
        tick();
        drive(1'b1, 32'd11, 32'h0000_0041);
        checks++; if (bus.int_valid !== 1'b1 || bus.int_data !== 32'hFFFF_FFFB)
            $display("FAIL int_strobe: got %b/%h want 1/fffffffb", bus.int_valid, bus.int_data); else passed++;
        checks++; if (bus.char_valid !== 1'b0 || bus.stall !== 1'b0)
            $display("FAIL int_no_char_stall: got %b/%b want 0/0", bus.char_valid, bus.stall); else passed++;
        tick();
        drive(1'b0, 32'd0, 32'd0);
        checks++; if (bus.char_valid !== 1'b1 || bus.char_data !== 8'h41)
            $display("FAIL char_strobe: got %b/%h want 1/41", bus.char_valid, bus.char_data); else passed++;
        checks++; if (bus.int_valid !== 1'b0) $display("FAIL int_one_shot: got %b want 0", bus.int_valid); else passed++;
        tick();
        checks++; if (bus.char_valid !== 1'b0) $display("FAIL char_one_shot: got %b want 0", bus.char_valid); else passed++;
        chars_q.delete();
    endtask

    task automatic test_string();
        int stall_cycles;
        bit done;
        mem[32'h100] = "H"; mem[32'h101] = "i"; mem[32'h102] = 8'h00;
        served_q.delete(); chars_q.delete(); unstable = 0; dly_idx = 0; dly_force = -1;
        drive(1'b1, 32'd4, 32'h100);
        #1;
        checks++; if (bus.stall !== 1'b1) $display("FAIL str_accept_stall: got %b want 1", bus.stall); else passed++;
        tick();
        drive(1'b0, 32'd0, 32'd0);
        stall_cycles = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (bus.stall !== 1'b1) done = 1; else begin stall_cycles++; tick(); end
        end
        checks++; if (!done) $display("FAIL str_timeout: stall still %b after 100 cycles", bus.stall); else passed++;
        // delays 0,3,1: (1+1)+(1+4)+(1+2) cycles after the accept cycle
        checks++; if (stall_cycles != 10) $display("FAIL str_stall_len: got %0d want 10", stall_cycles); else passed++;
        tick();
        checks++; if (chars_q.size() != 2 || chars_q[0] !== "H" || chars_q[1] !== "i")
            $display("FAIL str_chars: got %0d chars want \"Hi\"", chars_q.size()); else passed++;
        checks++; if (served_q.size() != 3 || served_q[0] !== 32'h100 || served_q[1] !== 32'h101 || served_q[2] !== 32'h102)
            $display("FAIL str_addrs: got %0d reads want 100,101,102", served_q.size()); else passed++;
        checks++; if (unstable != 0) $display("FAIL str_addr_stable: got %0d glitches want 0", unstable); else passed++;
        checks++; if (bus.err_overlong !== 1'b0) $display("FAIL str_no_overlong: got %b want 0", bus.err_overlong); else passed++;
    endtask

    task automatic test_overlong_wrap();
        bit done;
        served_q.delete(); chars_q.delete(); unstable = 0; dly_idx = 1;
        drive(1'b1, 32'd4, 32'hFFFF_FFFE);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (bus.stall !== 1'b1) done = 1; else tick();
        end
        checks++; if (!done) $display("FAIL ovl_timeout: stall still %b", bus.stall); else passed++;
        tick();
        checks++; if (chars_q.size() != 4) $display("FAIL ovl_char_count: got %0d want 4", chars_q.size()); else passed++;
        checks++; if (served_q.size() != 4 || served_q[0] !== 32'hFFFF_FFFE || served_q[1] !== 32'hFFFF_FFFF ||
                      served_q[2] !== 32'h0 || served_q[3] !== 32'h1)
            $display("FAIL ovl_addrs: got %0d reads want fffffffe,ffffffff,0,1", served_q.size()); else passed++;
        checks++; if (bus.err_overlong !== 1'b1) $display("FAIL ovl_flag: got %b want 1", bus.err_overlong); else passed++;
        checks++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0)
            $display("FAIL ovl_idle: got req %b stall %b want 0/0", bus.mem_req, bus.stall); else passed++;
        checks++; if (unstable != 0) $display("FAIL ovl_addr_stable: got %0d glitches want 0", unstable); else passed++;
    endtask

    task automatic test_represent();
        bit done;
        mem[32'h200] = "a"; mem[32'h201] = "b"; mem[32'h202] = "c"; mem[32'h203] = 8'h00;
        served_q.delete(); chars_q.delete(); dly_idx = 2;
        drive(1'b1, 32'd4, 32'h200);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (bus.mem_req !== 1'b1) done = 1;
        end
        drive(1'b0, 32'd0, 32'd0);
        checks++; if (!done) $display("FAIL rep_timeout: mem_req still %b", bus.mem_req); else passed++;
        tick(); tick();
        checks++; if (chars_q.size() != 3 || chars_q[0] !== "a" || chars_q[1] !== "b" || chars_q[2] !== "c")
            $display("FAIL rep_once: got %0d chars want \"abc\"", chars_q.size()); else passed++;
        checks++; if (served_q.size() != 4) $display("FAIL rep_reads: got %0d want 4", served_q.size()); else passed++;
    endtask

    task automatic test_exit();
        chars_q.delete();
        drive(1'b1, 32'd10, 32'd0);
        tick();
        drive(1'b1, 32'd1, 32'd5);
        checks++; if (bus.exit_req !== 1'b1) $display("FAIL exit_set: got %b want 1", bus.exit_req); else passed++;
        tick();
        drive(1'b1, 32'd7, 32'd0);
        checks++; if (bus.int_valid !== 1'b0) $display("FAIL exit_no_int: got %b want 0", bus.int_valid); else passed++;
        tick();
        drive(1'b1, 32'd4, 32'h100);
        #1;
        checks++; if (bus.stall !== 1'b0) $display("FAIL exit_no_str_stall: got %b want 0", bus.stall); else passed++;
        tick();
        drive(1'b1, 32'd11, 32'h42);
        checks++; if (bus.err_badcode !== 1'b0) $display("FAIL exit_no_badcode: got %b want 0", bus.err_badcode); else passed++;
        tick();
        drive(1'b0, 32'd0, 32'd0);
        tick();
        checks++; if (chars_q.size() != 0 || bus.exit_req !== 1'b1)
            $display("FAIL exit_sticky: got %0d chars exit %b want 0/1", chars_q.size(), bus.exit_req); else passed++;
    endtask

    task automatic test_badcode_reset();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        drive(1'b1, 32'd7, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        checks++; if (bus.err_badcode !== 1'b1 || bus.stall !== 1'b0)
            $display("FAIL badcode: got %b stall %b want 1/0", bus.err_badcode, bus.stall); else passed++;
        dly_force = 3;
        drive(1'b1, 32'd4, 32'h300);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300)
            $display("FAIL rst_pre_wait: got req %b addr %h want 1/300", bus.mem_req, bus.mem_addr); else passed++;
        rst_n = 1'b0;
        tick();
        checks++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'd0)
            $display("FAIL rst_mid_walk: got stall %b req %b addr %h want 0/0/0", bus.stall, bus.mem_req, bus.mem_addr); else passed++;
        checks++; if ({bus.exit_req, bus.err_overlong, bus.err_badcode, bus.char_valid, bus.int_valid} !== 5'd0 ||
                      bus.int_data !== 32'd0 || bus.char_data !== 8'd0)
            $display("FAIL rst_mid_outputs: got flags %b want 00000", {bus.exit_req, bus.err_overlong, bus.err_badcode,
                     bus.char_valid, bus.int_valid}); else passed++;
        rst_n = 1'b1; dly_force = -1;
        tick();
        drive(1'b1, 32'd1, 32'h1234);
        tick();
        drive(1'b0, 32'd0, 32'd0);
        checks++; if (bus.int_valid !== 1'b1 || bus.int_data !== 32'h1234 || bus.stall !== 1'b0)
            $display("FAIL post_reset_int: got %b/%h want 1/1234", bus.int_valid, bus.int_data); else passed++;
    endtask

    initial begin
        checks = 0; passed = 0; unstable = 0; dly_idx = 0; dly_force = -1;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        test_reset();
        test_int_char();
        test_string();
        test_overlong_wrap();
        test_represent();
        test_exit();
        test_badcode_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Parametrised successor to the pipeline's syscall handler; sits beside the decode/execute stage and services SYSCALL using v0/a0.
- Adds a real print-string engine: it walks a NUL-terminated string through a byte read port, stalls the pipeline while walking, and emits one character per strobe.
- Also provides the print-int, print-char and exit services, plus sticky error reporting.
- Printing itself is done by the testbench/display sink from the output strobes; the block never calls $display.

Parameters:
- DATA_W, 32, width of v0/a0/int_data.
- ADDR_W, 32, byte-address width of the string read port.
- MAX_STR_LEN, 256, max non-NUL characters per string before abort (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- sig_syscall  in  1  SYSCALL in servicing stage this cycle
- v0  in  DATA_W  service code
- a0  in  DATA_W  argument
- stall  out  1  hold pipeline (combinational)
- mem_req  out  1  byte read request
- mem_addr  out  ADDR_W  byte address
- mem_rdata  in  8  returned byte
- mem_valid  in  1  mem_rdata valid, completes request
- char_valid  out  1  one-cycle character strobe
- char_data  out  8  character
- int_valid  out  1  one-cycle integer strobe
- int_data  out  DATA_W  integer (signed interpretation by sink)
- exit_req  out  1  sticky: program requested exit
- err_overlong  out  1  sticky: string hit MAX_STR_LEN
- err_badcode  out  1  sticky: unsupported v0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. Reset may be asserted mid-walk.
- Reset response: state IDLE; all outputs 0, including sticky flags; mem_addr 0; char counter 0.
- Accept condition: a syscall is accepted only when state==IDLE, sig_syscall==1 and exit_req==0.
- v0==1 (print int): int_valid=1 and int_data=a0 on the next cycle; no stall.
- v0==11 (print char): char_valid=1 and char_data=a0[7:0] on the next cycle; no stall.
- v0==10 (exit): exit_req set from the next cycle and held until reset. Later syscalls are ignored, with no strobes and no errors.
- v0==4 (print string): stall=1 combinationally in the accept cycle. mem_addr<=a0, counter<=0, go REQ.
- Any other v0: err_badcode set next cycle; no stall.
- State REQ: mem_req=1, stall=1; go WAIT.
- State WAIT: mem_req and mem_addr stay stable, stall=1, until mem_valid.
- On mem_valid with mem_rdata==0: go IDLE; stall drops in the IDLE cycle.
- On mem_valid with a non-zero byte: char_valid/char_data registered next cycle; mem_addr+=1, wrapping mod 2^ADDR_W; counter+=1.
  - If counter then equals MAX_STR_LEN: set err_overlong, go IDLE (the string is truncated after MAX_STR_LEN chars).
  - Otherwise go REQ.
- Throughput: 2 cycles per byte minimum, plus memory wait states. mem_valid outside WAIT is ignored.
- stall = (state!=IDLE) | (accept & v0==4).
- Simultaneous events:
  - sig_syscall while not IDLE is ignored (the pipeline is stalled, so it is a re-presentation of the same instruction).
  - The last char_valid of a string may coincide with the first IDLE cycle; a new syscall accepted in that cycle is legal.
- char_valid and int_valid are never high together except in that last-char/new-accept overlap, and a second v0==11 cannot occur there because the pipeline only issues one syscall per cycle.

Decomposition:
- Package syscall_pkg: service code constants SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_EXIT=10, SYS_PRINT_CHAR=11; state enum {IDLE, REQ, WAIT}.
- One sub-module is natural: syscall_str_walker (address/counter/FSM for v0==4). The top keeps decode, strobes and sticky flags.

Test Plan:
- Int and char: v0=1, a0=-5, then v0=11, a0=0x41 -> int_valid with int_data=0xFFFFFFFB, then char_valid with 'A'; stall never high.
- String: v0=4, a0=0x100, memory "Hi\0" with 0–3 cycle mem_valid delays.
  - Required: chars 'H','i' in order at addresses 0x100, 0x101; read of 0x102 returns 0.
  - Required: stall high from the accept cycle through the NUL cycle; mem_addr stable while waiting.
- Overlong and wrap: MAX_STR_LEN=4, a0=0xFFFFFFFE, all bytes non-zero.
  - Required: exactly 4 chars from addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
  - Required: err_overlong=1, then return to IDLE.
- Exit: v0=10, then v0=1 -> exit_req sticky high; no int_valid.
- Bad code and reset: v0=7 -> err_badcode=1. Then start a string and assert rst_n=0 mid-WAIT -> next cycle all outputs 0, state IDLE, flags cleared.
- Re-presentation: hold sig_syscall=1 with v0=4 throughout a 3-char walk -> string printed exactly once.
